// File: rtl/strip_serializer.sv
// WS2812-style frame serializer: snapshots a brightness-scaled pixel array and
// shifts it out GRB/MSB-first as timed high/low pulses, followed by a latch gap.
module strip_serializer #(
    parameter int NUM_LEDS     = 10,
    parameter int T0H          = 40,
    parameter int T0L          = 85,
    parameter int T1H          = 80,
    parameter int T1L          = 45,
    parameter int RESET_CYCLES = 5000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_LEDS-1:0][23:0] strip,
    input  logic [2:0]               brightness,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic                     dout
);

    localparam int MAX_HI  = (T0H > T1H) ? T0H : T1H;
    localparam int MAX_LO  = (T0L > T1L) ? T0L : T1L;
    localparam int MAX_BIT = (MAX_HI > MAX_LO) ? MAX_HI : MAX_LO;
    localparam int MAX_CNT = (MAX_BIT > RESET_CYCLES) ? MAX_BIT : RESET_CYCLES;
    localparam int TMR_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;
    localparam int LED_W   = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;

    localparam logic [TMR_W-1:0] T0H_M1   = TMR_W'(T0H - 1);
    localparam logic [TMR_W-1:0] T0L_M1   = TMR_W'(T0L - 1);
    localparam logic [TMR_W-1:0] T1H_M1   = TMR_W'(T1H - 1);
    localparam logic [TMR_W-1:0] T1L_M1   = TMR_W'(T1L - 1);
    localparam logic [TMR_W-1:0] LATCH_M1 = TMR_W'(RESET_CYCLES - 1);
    localparam logic [LED_W-1:0] LAST_LED = LED_W'(NUM_LEDS - 1);

    typedef enum logic [1:0] {IDLE, HIGH, LOW, LATCH} state_t;

    state_t                      state_q, state_d;
    logic [TMR_W-1:0]            timer_q, timer_d;
    logic [LED_W-1:0]            led_q, led_d;
    logic [4:0]                  bit_q, bit_d;
    logic [NUM_LEDS-1:0][23:0]   shadow_q, shadow_d;
    logic                        done_q, done_d;

    logic [NUM_LEDS-1:0][23:0]   scaled_in;
    logic [LED_W-1:0]            nxt_led;
    logic [4:0]                  nxt_bit;
    logic                        cur_val, nxt_val, last_bit;

    // Channel scale: keep bits [10:3] of c * (brightness + 1); 7 is unity gain.
    function automatic logic [7:0] scale_chan(input logic [7:0] c, input logic [2:0] b);
        logic [3:0]  m;
        logic [10:0] p;
        m = {1'b0, b} + 4'd1;
        p = {3'b000, c} * {7'd0, m};
        return p[10:3];
    endfunction

    // Shadow words are stored in transmit order (G, R, B) so bit 23 goes first.
    always_comb begin
        for (int i = 0; i < NUM_LEDS; i++) begin
            scaled_in[i] = {scale_chan(strip[i][15:8],  brightness),
                            scale_chan(strip[i][23:16], brightness),
                            scale_chan(strip[i][7:0],   brightness)};
        end
    end

    always_comb begin
        cur_val  = shadow_q[led_q][bit_q];
        last_bit = (led_q == LAST_LED) && (bit_q == 5'd0);
        if (bit_q == 5'd0) begin
            nxt_led = led_q + LED_W'(1);
            nxt_bit = 5'd23;
        end else begin
            nxt_led = led_q;
            nxt_bit = bit_q - 5'd1;
        end
        nxt_val = last_bit ? 1'b0 : shadow_q[nxt_led][nxt_bit];
    end

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        led_d    = led_q;
        bit_d    = bit_q;
        shadow_d = shadow_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    shadow_d = scaled_in;
                    led_d    = '0;
                    bit_d    = 5'd23;
                    timer_d  = scaled_in[0][23] ? T1H_M1 : T0H_M1;
                    state_d  = HIGH;
                end
            end
            HIGH: begin
                if (timer_q == '0) begin
                    timer_d = cur_val ? T1L_M1 : T0L_M1;
                    state_d = LOW;
                end else begin
                    timer_d = timer_q - TMR_W'(1);
                end
            end
            LOW: begin
                if (timer_q == '0) begin
                    if (last_bit) begin
                        timer_d = LATCH_M1;
                        state_d = LATCH;
                    end else begin
                        led_d   = nxt_led;
                        bit_d   = nxt_bit;
                        timer_d = nxt_val ? T1H_M1 : T0H_M1;
                        state_d = HIGH;
                    end
                end else begin
                    timer_d = timer_q - TMR_W'(1);
                end
            end
            LATCH: begin
                if (timer_q == '0) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    timer_d = timer_q - TMR_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            timer_q  <= '0;
            led_q    <= '0;
            bit_q    <= '0;
            shadow_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            led_q    <= led_d;
            bit_q    <= bit_d;
            shadow_q <= shadow_d;
            done_q   <= done_d;
        end
    end

    assign dout = (state_q == HIGH);
    assign busy = (state_q != IDLE);
    assign done = done_q;

endmodule

// File: tb/tb_strip_serializer.sv
// Bench for strip_serializer: a frame-level reference model predicts dout/busy/done
// every cycle, plus directed pulse-width and frame-length expectations.
module tb_strip_serializer;

    localparam int NUM_LEDS = 2;
    localparam int T0H = 2, T0L = 4, T1H = 4, T1L = 2, RESET_CYCLES = 10;
    localparam int P     = T0H + T0L;
    localparam int NBITS = NUM_LEDS * 24;
    localparam int FLEN  = NBITS * P + RESET_CYCLES;

    logic                      clk = 1'b0;
    logic                      rst;
    logic [NUM_LEDS-1:0][23:0] strip;
    logic [2:0]                brightness;
    logic                      start;
    logic                      busy, done, dout;

    int n_assert = 0;
    int n_fail   = 0;

    strip_serializer #(
        .NUM_LEDS(NUM_LEDS), .T0H(T0H), .T0L(T0L), .T1H(T1H), .T1L(T1L),
        .RESET_CYCLES(RESET_CYCLES)
    ) dut (
        .clk(clk), .rst(rst), .strip(strip), .brightness(brightness),
        .start(start), .busy(busy), .done(done), .dout(dout)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    bit mvalid  = 1'b0;
    bit mactive = 1'b0;
    bit mdone   = 1'b0;
    int mk      = 0;
    bit mbits[NBITS];

    function automatic int model_scale(input int c, input int b);
        return (c * (b + 1)) / 8;
    endfunction

    function automatic bit exp_dout();
        int b, off;
        if (!mactive) return 1'b0;
        b   = mk / P;
        off = mk % P;
        if (b >= NBITS) return 1'b0;
        return (off < (mbits[b] ? T1H : T0H));
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            mvalid  = 1'b1;
            mactive = 1'b0;
            mdone   = 1'b0;
        end else if (mactive) begin
            mk++;
            if (mk == FLEN) begin
                mactive = 1'b0;
                mdone   = 1'b1;
            end
        end else begin
            mdone = 1'b0;
            if (start) begin
                for (int l = 0; l < NUM_LEDS; l++) begin
                    int w, ch[3];
                    w     = int'(strip[l]);
                    ch[0] = model_scale((w >> 8) & 255, int'(brightness));
                    ch[1] = model_scale((w >> 16) & 255, int'(brightness));
                    ch[2] = model_scale(w & 255, int'(brightness));
                    for (int c = 0; c < 3; c++)
                        for (int bi = 7; bi >= 0; bi--)
                            mbits[l*24 + c*8 + (7-bi)] = bit'((ch[c] >> bi) & 1);
                end
                mactive = 1'b1;
                mk      = 0;
            end
        end
    end

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t actual=%b required=%b", name, $time, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_assert++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s t=%0t actual=%0d required=%0d", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mvalid) begin
            check_bit("model_dout", dout, exp_dout());
            check_bit("model_busy", busy, mactive);
            check_bit("model_done", done, mdone);
        end
    end

    // ---------------- pulse recorders ----------------
    int widths[$];
    int busy_runs[$];
    int exp_w[$];
    int hrun = 0, brun = 0;

    always @(negedge clk) begin
        if (dout === 1'b1) hrun++;
        else if (hrun > 0) begin widths.push_back(hrun); hrun = 0; end
        if (busy === 1'b1) brun++;
        else if (brun > 0) begin busy_runs.push_back(brun); brun = 0; end
    end

    task automatic check_widths(input string name);
        int bad;
        bad = -1;
        if (widths.size() != exp_w.size()) bad = 9999;
        else
            for (int i = 0; i < widths.size(); i++)
                if (bad < 0 && widths[i] != exp_w[i]) bad = i;
        n_assert++;
        if (bad >= 0) begin
            n_fail++;
            if (bad == 9999)
                $display("FAIL %s pulse count actual=%0d required=%0d", name, widths.size(), exp_w.size());
            else
                $display("FAIL %s pulse %0d width actual=%0d required=%0d", name, bad, widths[bad], exp_w[bad]);
        end
    endtask

    task automatic push_byte(input int v);
        for (int bi = 7; bi >= 0; bi--) exp_w.push_back(((v >> bi) & 1) ? T1H : T0H);
    endtask

    task automatic wait_done(input int budget, output int waited);
        waited = 0;
        while (done !== 1'b1 && waited < budget) begin
            @(negedge clk);
            waited++;
        end
        if (done !== 1'b1) begin
            n_assert++;
            n_fail++;
            $display("FAIL done_timeout t=%0t actual=no_done required=done", $time);
        end
    endtask

    // Pulse start for one cycle, wait for done, check frame length in edges after accept.
    task automatic run_frame(input string name);
        int w;
        widths.delete();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(FLEN + 50, w);
        check_int(name, w, 298);
        @(negedge clk);
    endtask

    initial begin
        int w;
        rst = 1'b1; start = 1'b0; strip = '0; brightness = 3'd0;
        repeat (3) @(negedge clk);

        // model pins
        check_int("scale_ff_b7", model_scale(255, 7), 255);
        check_int("scale_ff_b3", model_scale(255, 3), 127);
        check_int("scale_ff_b0", model_scale(255, 0), 31);
        check_int("frame_len_const", FLEN, 298);

        // reset held with start high
        start = 1'b1; brightness = 3'd7;
        strip = {24'h0000FF, 24'hFF0000};
        repeat (2) begin
            @(negedge clk);
            check_bit("rst_dout", dout, 1'b0);
            check_bit("rst_busy", busy, 1'b0);
            check_bit("rst_done", done, 1'b0);
        end
        rst = 1'b0;
        widths.delete();
        @(negedge clk);
        start = 1'b0;
        check_bit("first_accept_dout", dout, 1'b1);
        check_bit("first_accept_busy", busy, 1'b1);
        wait_done(FLEN + 50, w);
        check_int("first_frame_len", w, 298);
        @(negedge clk);

        // full brightness
        run_frame("full_frame_len");
        exp_w.delete();
        push_byte(8'h00); push_byte(8'hFF); push_byte(8'h00);
        push_byte(8'h00); push_byte(8'h00); push_byte(8'hFF);
        check_widths("full_widths");
        check_int("full_busy_len", (busy_runs.size() > 0) ? busy_runs[$] : -1, 298);

        // scaling
        strip = {24'hFFFFFF, 24'hFFFFFF};
        brightness = 3'd3;
        run_frame("b3_frame_len");
        exp_w.delete();
        repeat (6) push_byte(8'h7F);
        check_widths("b3_widths");
        brightness = 3'd0;
        run_frame("b0_frame_len");
        exp_w.delete();
        repeat (6) push_byte(8'h1F);
        check_widths("b0_widths");

        // input isolation with start held high
        brightness = 3'd7;
        widths.delete();
        start = 1'b1;
        @(negedge clk);
        w = 0;
        while (w < 50) begin @(negedge clk); w++; end
        strip = '0; brightness = 3'd0;
        begin
            int w2;
            wait_done(FLEN, w2);
            check_int("iso_a_len", w + w2, 298);
        end
        exp_w.delete();
        repeat (6) push_byte(8'hFF);
        check_widths("iso_a_widths");
        widths.delete();
        @(negedge clk);
        start = 1'b0;
        check_bit("iso_b_started", busy, 1'b1);
        wait_done(FLEN + 50, w);
        check_int("iso_b_len", w, 298);
        exp_w.delete();
        repeat (6) push_byte(8'h00);
        check_widths("iso_b_widths");
        @(negedge clk);

        // mid-frame reset
        strip = {24'($urandom()), 24'($urandom())};
        brightness = 3'($urandom());
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (100) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_bit("midrst_dout", dout, 1'b0);
        check_bit("midrst_busy", busy, 1'b0);
        w = 0;
        repeat (FLEN + 20) begin @(negedge clk); if (done === 1'b1) w++; end
        check_int("midrst_no_done", w, 0);
        strip = {24'h0000FF, 24'hFF0000};
        brightness = 3'd7;
        run_frame("post_rst_len");
        exp_w.delete();
        push_byte(8'h00); push_byte(8'hFF); push_byte(8'h00);
        push_byte(8'h00); push_byte(8'h00); push_byte(8'hFF);
        check_widths("post_rst_widths");

        // randomized frames, input changes and resets
        for (int it = 0; it < 10; it++) begin
            strip = {24'($urandom()), 24'($urandom())};
            brightness = 3'($urandom());
            start = 1'b1;
            repeat ($urandom_range(1, 3)) @(negedge clk);
            start = 1'b0;
            repeat ($urandom_range(10, 250)) @(negedge clk);
            strip = {24'($urandom()), 24'($urandom())};
            brightness = 3'($urandom());
            if (it % 4 == 3) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end else begin
                wait_done(FLEN + 50, w);
            end
            repeat ($urandom_range(1, 4)) @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
